// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants and the PC sequencer state encoding.
package riscv_pkg;
   localparam int unsigned XLEN    = 32;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_INCR = 4;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {
      BOOT,
      REQ,
      WAIT,
      HOLD,
      FAULT
   } pc_seq_state_e;
endpackage

// File: rtl/pc_sequencer_pc_adder.sv
// Sequential next-PC adder (pc + 4, wrapping modulo 2^XLEN).
module PC_Adder #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] i_pc,
   output logic [XLEN-1:0] o_pc_next
);
   import riscv_pkg::*;

   assign o_pc_next = i_pc + XLEN'(PC_INCR);
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC, issues single-outstanding imem fetches,
// and hands instructions to decode; trap > redirect > sequential next-PC.
module pc_sequencer #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        imem_req_valid,
   input  logic                        imem_req_ready,
   output logic [XLEN-1:0]             imem_addr,
   input  logic                        imem_rsp_valid,
   input  logic [riscv_pkg::INSTR_W-1:0] imem_rsp_data,
   output logic                        if_valid,
   output logic [XLEN-1:0]             if_pc,
   output logic [riscv_pkg::INSTR_W-1:0] if_instr,
   input  logic                        id_ready,
   input  logic                        redirect_valid,
   input  logic [XLEN-1:0]             redirect_target,
   input  logic                        trap_valid,
   input  logic [XLEN-1:0]             trap_vector,
   output logic                        misalign_exc,
   output logic [XLEN-1:0]             misalign_addr
);
   import riscv_pkg::*;

   pc_seq_state_e        r_state, w_nxt_state;
   logic [XLEN-1:0]      r_pc, w_nxt_pc, w_pc_inc, w_trap_pc, w_new_pc;
   logic                 r_discard, w_nxt_discard;
   logic                 r_req_valid, r_if_valid, r_mis_exc;
   logic [XLEN-1:0]      r_if_pc, r_mis_addr;
   logic [INSTR_W-1:0]   r_if_instr;
   logic                 w_fire, w_redir, w_redir_bad, w_busy;
   logic                 w_capture, w_fault_set, w_fault_clr;

   PC_Adder #(.XLEN(XLEN)) u_pc_adder (
      .i_pc      (r_pc),
      .o_pc_next (w_pc_inc)
   );

   assign w_trap_pc   = trap_vector & ~XLEN'(3);
   assign w_redir     = redirect_valid && !trap_valid;
   assign w_redir_bad = w_redir && (redirect_target[1:0] != 2'b00);
   assign w_new_pc    = trap_valid ? w_trap_pc : redirect_target;
   assign w_fire      = (r_state == REQ) && imem_req_ready;

   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_pc      = r_pc;
      w_nxt_discard = r_discard;
      w_capture     = 1'b0;
      w_fault_set   = 1'b0;
      w_fault_clr   = 1'b0;
      w_busy        = 1'b0;
      case (r_state)
         BOOT: w_nxt_state = REQ;
         REQ:  if (w_fire) w_nxt_state = WAIT;
         WAIT: begin
            if (imem_rsp_valid) begin
               if (r_discard) begin
                  w_nxt_discard = 1'b0;
                  w_nxt_state   = REQ;
               end else begin
                  w_capture   = 1'b1;
                  w_nxt_state = HOLD;
               end
            end
         end
         HOLD: begin
            if (id_ready) begin
               w_nxt_pc    = w_pc_inc;
               w_nxt_state = REQ;
            end
         end
         FAULT: begin
            if (imem_rsp_valid) w_nxt_discard = 1'b0;
            // A fetch still in flight must drain in WAIT before a new request
            if (trap_valid) begin
               w_nxt_pc    = w_trap_pc;
               w_fault_clr = 1'b1;
               w_nxt_state = (r_discard && !imem_rsp_valid) ? WAIT : REQ;
            end
         end
         default: w_nxt_state = BOOT;
      endcase

      if ((r_state inside {REQ, WAIT, HOLD}) && (trap_valid || w_redir)) begin
         w_busy        = w_fire || ((r_state == WAIT) && !imem_rsp_valid);
         w_nxt_discard = w_busy;
         w_capture     = 1'b0;
         if (w_redir_bad) begin
            w_nxt_pc    = r_pc;
            w_fault_set = 1'b1;
            w_nxt_state = FAULT;
         end else begin
            w_nxt_pc    = w_new_pc;
            w_nxt_state = w_busy ? WAIT : REQ;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= BOOT;
         r_pc        <= RESET_VECTOR;
         r_discard   <= 1'b0;
         r_req_valid <= 1'b0;
         r_if_valid  <= 1'b0;
         r_if_pc     <= '0;
         r_if_instr  <= NOP_INSTR;
         r_mis_exc   <= 1'b0;
         r_mis_addr  <= '0;
      end else begin
         r_state     <= w_nxt_state;
         r_pc        <= w_nxt_pc;
         r_discard   <= w_nxt_discard;
         r_req_valid <= (w_nxt_state == REQ);
         r_if_valid  <= (w_nxt_state == HOLD);
         if (w_capture) begin
            r_if_instr <= imem_rsp_data;
            r_if_pc    <= r_pc;
         end
         if (w_fault_set) begin
            r_mis_exc  <= 1'b1;
            r_mis_addr <= redirect_target;
         end else if (w_fault_clr) begin
            r_mis_exc  <= 1'b0;
         end
      end
   end

   assign imem_req_valid = r_req_valid;
   assign imem_addr      = r_pc;
   assign if_valid       = r_if_valid;
   assign if_pc          = r_if_pc;
   assign if_instr       = r_if_instr;
   assign misalign_exc   = r_mis_exc;
   assign misalign_addr  = r_mis_addr;
endmodule
